// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HALTED = 2'd2,
      FAULT  = 2'd3
   } fetch_state_t;

   localparam int unsigned WORD_BYTES = 4;

   // A redirect target must be word aligned and address a whole word inside memory.
   function automatic logic target_ok(input logic [31:0] target, input logic [31:0] mem_bytes);
      return (target[1:0] == 2'b00) && (target <= mem_bytes - 32'(WORD_BYTES));
   endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready holding register for fetched instruction words and their PCs.
module fetch_out_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        flush,
   input  logic        pop,
   input  logic [31:0] load_data,
   input  logic [31:0] load_pc,
   output logic        valid,
   output logic        valid_next,
   output logic [31:0] data,
   output logic [31:0] pc
);

   // Flush beats load beats pop; data and pc only change on a load.
   always_comb begin
      valid_next = valid;
      if (flush)
         valid_next = 1'b0;
      else if (load)
         valid_next = 1'b1;
      else if (pop)
         valid_next = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         pc    <= '0;
      end else begin
         valid <= valid_next;
         if (load && !flush) begin
            data <= load_data;
            pc   <= load_pc;
         end
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches one word per cycle into a
// one-entry output register, and handles redirects, halting and faults.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 60,
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_instr,
   input  logic             redirect,
   input  logic [31:0]      redirect_target,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [31:0]      inst_data,
   output logic [31:0]      inst_pc,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] fetch_count
);

   fetch_state_t state, state_n;
   logic [31:0]  pc, pc_n;
   logic [32:0]  pc_plus4;
   logic         slot_free, transfer, redirect_act, start_act, load, at_end, valid_next;

   assign imem_addr = pc;

   always_comb begin
      slot_free    = !inst_valid || inst_ready;
      transfer     = inst_valid && inst_ready;
      redirect_act = redirect && (state == FETCH || state == HALTED);
      start_act    = start && !redirect_act && (state == IDLE || state == HALTED);
      load         = (state == FETCH) && slot_free && !redirect_act;
      // 33-bit sum so the end-of-memory test cannot be fooled by PC wrap.
      pc_plus4     = {1'b0, pc} + 33'(WORD_BYTES);
      at_end       = (imem_instr == HALT_WORD) || (pc_plus4 >= 33'(MEM_BYTES));
      state_n      = state;
      pc_n         = pc;
      if (redirect_act) begin
         if (target_ok(redirect_target, 32'(MEM_BYTES))) begin
            state_n = FETCH;
            pc_n    = redirect_target;
         end else begin
            state_n = FAULT;
         end
      end else if (start_act) begin
         state_n = FETCH;
         pc_n    = RESET_PC;
      end else if (load) begin
         pc_n = pc_plus4[31:0];
         if (at_end)
            state_n = HALTED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         halted      <= 1'b0;
         fault       <= 1'b0;
         fetch_count <= '0;
      end else begin
         state  <= state_n;
         pc     <= pc_n;
         halted <= (state_n == HALTED) && !valid_next;
         fault  <= (state_n == FAULT);
         if (start_act)
            fetch_count <= '0;
         else if (transfer && fetch_count != '1)
            fetch_count <= fetch_count + CNT_W'(1);
      end
   end

   fetch_out_reg u_out_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .flush      (redirect_act),
      .pop        (transfer),
      .load_data  (imem_instr),
      .load_pc    (pc),
      .valid      (inst_valid),
      .valid_next (valid_next),
      .data       (inst_data),
      .pc         (inst_pc)
   );

endmodule
